// File: rtl/mant_expand_align_pkg.sv
`default_nettype none
// ============================================================================
// mant_expand_align_pkg : shared geometry, clamp helpers and beat type
// Rev 1.0
// ============================================================================
package mant_expand_align_pkg;

  localparam int DEF_WORK_WIDTH = 32;
  localparam int DEF_MANT_WIDTH = 24;

  // Clamp limits for a signed field of the given width (width <= 64).
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

  typedef struct packed {
    logic signed [DEF_MANT_WIDTH-1:0]       mant;
    logic [$clog2(DEF_WORK_WIDTH):0]        shift;
  } exp_align_beat_t;

endpackage
`default_nettype wire

// File: rtl/lead_sign_count.sv
`default_nettype none
// ============================================================================
// lead_sign_count : number of redundant sign bits below the MSB (0..W-1)
// Rev 1.0
// ============================================================================
module lead_sign_count #(
  parameter int W = 24
) (
  input  logic [W-1:0]         x,
  output logic [$clog2(W)-1:0] cnt
);

  logic r_run_unused;
  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[W-1])) cnt = cnt + 1'b1;
      else                         run = 1'b0;
    end
  end

  assign r_run_unused = run;

endmodule
`default_nettype wire

// File: rtl/mant_expand_align.sv
`default_nettype none
// ============================================================================
// mant_expand_align : mant * 2^(DROP + shift) onto the accumulator grid,
//                     saturating, 2-stage valid/ready pipeline
// Rev 1.0
// ============================================================================
module mant_expand_align
  import mant_expand_align_pkg::*;
#(
  parameter int WORK_WIDTH = DEF_WORK_WIDTH,
  parameter int MANT_WIDTH = DEF_MANT_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [MANT_WIDTH-1:0]    mant_in,
  input  logic [$clog2(WORK_WIDTH):0]     shift_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [WORK_WIDTH-1:0]    out_val,
  output logic                            out_sat,
  input  logic                            sat_clr,
  output logic [CNT_WIDTH-1:0]            sat_count
);

  localparam int SHW  = $clog2(WORK_WIDTH) + 1;
  localparam int RW   = $clog2(MANT_WIDTH);
  localparam int AW   = SHW + 1;
  localparam int DROP = WORK_WIDTH - MANT_WIDTH;

  localparam logic [WORK_WIDTH-1:0] WORK_MAX = WORK_WIDTH'(sat_max(WORK_WIDTH));
  localparam logic [WORK_WIDTH-1:0] WORK_MIN = WORK_WIDTH'(sat_min(WORK_WIDTH));
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  typedef struct packed {
    logic signed [MANT_WIDTH-1:0] mant;
    logic [SHW-1:0]               shift;
    logic                         ovf;
  } s1_beat_t;

  logic [RW-1:0]          w_rsb;
  logic                   w_ovf;
  logic                   w_s1_adv;
  logic                   w_s2_adv;
  logic [AW-1:0]          w_amt;
  logic [WORK_WIDTH-1:0]  w_ext;
  logic [WORK_WIDTH-1:0]  w_res;

  logic                   r_s1_v;
  s1_beat_t               r_s1;
  logic                   r_s2_v;
  logic [WORK_WIDTH-1:0]  r_s2_val;
  logic                   r_s2_sat;
  logic [CNT_WIDTH-1:0]   r_cnt;

  lead_sign_count #(.W(MANT_WIDTH)) u_lsc (
    .x   (mant_in),
    .cnt (w_rsb)
  );

  // A zero mantissa never overflows, whatever the shift.
  assign w_ovf = (mant_in != '0) && (32'(shift_in) > 32'(w_rsb));

  assign w_s2_adv = !r_s2_v || out_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Without overflow DROP+shift never exceeds the headroom, so the shift is exact.
  assign w_amt = AW'(DROP) + AW'(r_s1.shift);
  assign w_ext = WORK_WIDTH'($signed(r_s1.mant));

  always_comb begin
    w_res = w_ext << w_amt;
    if (r_s1.ovf) w_res = r_s1.mant[MANT_WIDTH-1] ? WORK_MIN : WORK_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1     <= '0;
      r_s2_v   <= 1'b0;
      r_s2_val <= '0;
      r_s2_sat <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= in_valid;
        if (in_valid) r_s1 <= '{mant: mant_in, shift: shift_in, ovf: w_ovf};
      end
      if (w_s2_adv) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_val <= w_res;
          r_s2_sat <= r_s1.ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_cnt <= '0;
    else if (sat_clr)                                    r_cnt <= '0;
    else if (r_s2_v && out_ready && r_s2_sat && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid = r_s2_v;
  assign out_val   = r_s2_val;
  assign out_sat   = r_s2_sat;
  assign sat_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mant_expand_align.sv
`default_nettype none
// ============================================================================
// tb_mant_expand_align : directed self-checking bench (32/24 geometry, 4-bit counter)
// Rev 1.0
// ============================================================================
module tb_mant_expand_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] mant_in;
  logic [5:0]  shift_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_val;
  logic        out_sat;
  logic        sat_clr;
  logic [3:0]  sat_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mant_expand_align #(.WORK_WIDTH(32), .MANT_WIDTH(24), .CNT_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .shift_in  (shift_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated beat: accept, latency, result, then counter after consumption.
  task automatic vec(input string tag, input logic [23:0] m, input logic [5:0] s,
                     input logic [31:0] ev, input logic es, input logic clr);
    in_valid = 1'b1; mant_in = m; shift_in = s;
    #1 check({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_val"}, out_val, ev);
    check({tag, "_sat"}, out_sat, es);
    sat_clr = clr;
    if (clr) exp_cnt = 0;
    else if (es && exp_cnt != 15) exp_cnt++;
    @(negedge clk);
    sat_clr = 1'b0;
    check({tag, "_cnt"}, sat_count, exp_cnt);
  endtask

  // Back-to-back saturating beats, then drain.
  task automatic stream(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; mant_in = 24'h7FFFFF; shift_in = 6'd1;
      @(negedge clk);
      if (exp_cnt != 15) exp_cnt++;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [23:0] bm [4];
  logic [5:0]  bs [4];
  logic [31:0] bv [4];
  int idx, got, first, last;
  logic acc;

  initial begin
    bm = '{24'h000001, 24'h000002, 24'h000003, 24'h7FFFFF};
    bs = '{6'd0, 6'd0, 6'd1, 6'd0};
    bv = '{32'h00000100, 32'h00000200, 32'h00000600, 32'h7FFFFF00};

    rst_n = 1'b0; in_valid = 1'b0; mant_in = '0; shift_in = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_val", out_val, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_count", sat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    vec("one",      24'h000001, 6'd0,  32'h00000100, 1'b0, 1'b0);
    vec("max_sat",  24'h7FFFFF, 6'd1,  32'h7FFFFFFF, 1'b1, 1'b0);
    vec("m1_s23",   24'hFFFFFF, 6'd23, 32'h80000000, 1'b0, 1'b0);
    vec("m1_s24",   24'hFFFFFF, 6'd24, 32'h80000000, 1'b1, 1'b0);
    vec("zero_s32", 24'h000000, 6'd32, 32'h00000000, 1'b0, 1'b0);
    vec("c0_s1",    24'hC00000, 6'd1,  32'h80000000, 1'b0, 1'b0);
    vec("40_s1",    24'h400000, 6'd1,  32'h7FFFFFFF, 1'b1, 1'b0);
    vec("one_s22",  24'h000001, 6'd22, 32'h40000000, 1'b0, 1'b0);
    vec("min_s0",   24'h800000, 6'd0,  32'h80000000, 1'b0, 1'b0);
    vec("min_s1",   24'h800000, 6'd1,  32'h80000000, 1'b1, 1'b0);

    // Stall: out_ready low for 5 cycles while 4 beats are offered.
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin in_valid = 1'b1; mant_in = bm[idx]; shift_in = bs[idx]; end
      #1 acc = in_ready;
      if (c >= 2) check("bp_hold", out_val, bv[0]);
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);

    out_ready = 1'b1; got = 0; first = -1; last = -1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (idx < 4) begin in_valid = 1'b1; mant_in = bm[idx]; shift_in = bs[idx]; end
      else in_valid = 1'b0;
      #1 acc = in_ready;
      if (out_valid) begin
        check("bp_order", out_val, bv[got]);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_got", got, 4);
    check("bp_rate", last - first, 3);
    repeat (2) @(negedge clk);

    stream(11);
    check("cnt_full", sat_count, 4'hF);
    check("cnt_model", sat_count, exp_cnt);
    stream(3);
    check("cnt_hold", sat_count, 4'hF);

    vec("clr_evt", 24'h7FFFFF, 6'd1, 32'h7FFFFFFF, 1'b1, 1'b1);
    vec("after_clr", 24'hFFFFFF, 6'd24, 32'h80000000, 1'b1, 1'b0);

    // Reset mid-stream drops in-flight beats.
    in_valid = 1'b1; mant_in = 24'h000005; shift_in = 6'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_val", out_val, 0);
    check("mrst_sat_count", sat_count, 0);
    exp_cnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mrst_no_stale", out_valid, 0);
    end
    vec("post_rst", 24'h000001, 6'd0, 32'h00000100, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
